// File: rtl/chacha_inv_permute.sv
// -----------------------------------------------------------------------------
// chacha_inv_permute
//
// Iterative inverse of the ChaCha block permutation (no feed-forward add).
// A 16-word state that went through ROUNDS forward rounds is rewound to the
// original pre-round state. One inverse half-double-round is applied per
// clock: a DIAG cycle (four diagonal inverse quarter-rounds in parallel)
// followed by a COL cycle (four column inverse quarter-rounds), repeated
// ROUNDS/2 times.
//
// Parameters
//   ROUNDS      forward rounds to undo; must be even and >= 2.
//
// Ports
//   clk         clock, rising edge.
//   rst         asynchronous active-high reset.
//   in_valid    state_in is valid (sampled only in IDLE).
//   in_ready    block can accept a state (high only in IDLE).
//   state_in    forward-permuted state, word i at [32i+31:32i].
//   out_valid   state_out holds the recovered state (DONE).
//   out_ready   downstream accepts state_out.
//   state_out   recovered state, same packing, straight from the working reg.
//   busy        high in DIAG, COL and DONE.
//   blocks_done completed output handshakes, wraps at 2^32
//               (present only when CHACHA_INV_PERF_EN is defined).
//
// Optional feature macro: CHACHA_INV_PERF_EN
// -----------------------------------------------------------------------------
module chacha_inv_permute #(
    parameter int ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] state_out,
`ifdef CHACHA_INV_PERF_EN
    output logic [31:0]  blocks_done,
`endif
    output logic         busy
);

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
        $error("chacha_inv_permute: ROUNDS must be even and at least 2");
    end

    localparam int CNT_W = $clog2(ROUNDS / 2 + 1);
    localparam logic [CNT_W-1:0] DR_LOAD = CNT_W'(ROUNDS / 2);
    localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(1);

    // Word i of the state is element [i] of this packed array, which matches
    // the [32i+31:32i] port packing bit for bit.
    typedef logic [15:0][31:0] state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIAG = 2'd1,
        S_COL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    state_t           work_q, work_d;
    logic [CNT_W-1:0] dr_cnt_q, dr_cnt_d;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Inverse quarter-round on words (ia,ib,ic,id): the forward steps undone
    // in reverse order, subtraction replacing addition and ROTR replacing ROTL.
    function automatic state_t inv_qr_at(input state_t s,
                                         input logic [3:0] ia,
                                         input logic [3:0] ib,
                                         input logic [3:0] ic,
                                         input logic [3:0] id);
        state_t      r;
        logic [31:0] a, b, c, d;
        r = s;
        a = s[ia];
        b = s[ib];
        c = s[ic];
        d = s[id];
        b = rotr(b, 7) ^ c;
        c = c - d;
        d = rotr(d, 8) ^ a;
        a = a - b;
        b = rotr(b, 12) ^ c;
        c = c - d;
        d = rotr(d, 16) ^ a;
        a = a - b;
        r[ia] = a;
        r[ib] = b;
        r[ic] = c;
        r[id] = d;
        return r;
    endfunction

    // The four quarter-rounds of a set touch disjoint words, so applying them
    // in sequence here is the same as applying them in parallel.
    function automatic state_t inv_diag(input state_t s);
        state_t r;
        r = inv_qr_at(s, 4'd0, 4'd5, 4'd10, 4'd15);
        r = inv_qr_at(r, 4'd1, 4'd6, 4'd11, 4'd12);
        r = inv_qr_at(r, 4'd2, 4'd7, 4'd8,  4'd13);
        r = inv_qr_at(r, 4'd3, 4'd4, 4'd9,  4'd14);
        return r;
    endfunction

    function automatic state_t inv_col(input state_t s);
        state_t r;
        r = inv_qr_at(s, 4'd0, 4'd4, 4'd8,  4'd12);
        r = inv_qr_at(r, 4'd1, 4'd5, 4'd9,  4'd13);
        r = inv_qr_at(r, 4'd2, 4'd6, 4'd10, 4'd14);
        r = inv_qr_at(r, 4'd3, 4'd7, 4'd11, 4'd15);
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_DIAG;
            S_DIAG: state_d = S_COL;
            S_COL:  state_d = (dr_cnt_q == DR_LAST) ? S_DONE : S_DIAG;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register only, so no handshake input
    // ever reaches a handshake output combinationally.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
    end

    // Working register and double-round counter
    always_comb begin
        work_d   = work_q;
        dr_cnt_d = dr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d   = state_in;
                    dr_cnt_d = DR_LOAD;
                end
            end
            S_DIAG: work_d = inv_diag(work_q);
            S_COL: begin
                work_d   = inv_col(work_q);
                dr_cnt_d = dr_cnt_q - DR_LAST;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q   <= '0;
            dr_cnt_q <= '0;
        end else begin
            work_q   <= work_d;
            dr_cnt_q <= dr_cnt_d;
        end
    end

    assign state_out = work_q;

`ifdef CHACHA_INV_PERF_EN
    logic [31:0] blocks_done_q, blocks_done_d;

    // Natural 32-bit wrap from 0xFFFFFFFF to 0.
    always_comb begin
        blocks_done_d = blocks_done_q;
        if (out_valid && out_ready) begin
            blocks_done_d = blocks_done_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_done_q <= '0;
        end else begin
            blocks_done_q <= blocks_done_d;
        end
    end

    assign blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_chacha_inv_permute.sv
// -----------------------------------------------------------------------------
// tb_chacha_inv_permute
//
// Three instances (ROUNDS = 20, 2, 8). Stimulus pushes the expected original
// state into a per-instance queue at the accept edge; a per-instance monitor
// pops and compares on every output handshake and checks latency on every
// rising out_valid. Expected states come from a forward ChaCha model.
// -----------------------------------------------------------------------------
module tb_chacha_inv_permute;

    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [NI];
    logic         in_ready  [NI];
    logic [511:0] state_in  [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [511:0] state_out [NI];
    logic         busy      [NI];
`ifdef CHACHA_INV_PERF_EN
    logic [31:0]  blocks_done [NI];
`endif

    logic [511:0] exp_q [NI][$];
    longint       acc_q [NI][$];
    longint       cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rounds_of(input int g);
        return (g == 0) ? 20 : ((g == 1) ? 2 : 8);
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %s", name, what);
    endtask

    // ---------------- forward reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [511:0] fwd(input logic [511:0] s, input int r);
        int qi [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        logic [31:0]  x [16];
        logic [31:0]  a, b, c, d;
        logic [511:0] o;
        for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
        for (int n = 0; n < r / 2; n++) begin
            for (int q = 0; q < 8; q++) begin
                a = x[qi[q][0]]; b = x[qi[q][1]]; c = x[qi[q][2]]; d = x[qi[q][3]];
                a = a + b; d = rotl(d ^ a, 16);
                c = c + d; b = rotl(b ^ c, 12);
                a = a + b; d = rotl(d ^ a, 8);
                c = c + d; b = rotl(b ^ c, 7);
                x[qi[q][0]] = a; x[qi[q][1]] = b; x[qi[q][2]] = c; x[qi[q][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
        return o;
    endfunction

    function automatic logic [511:0] rand_state();
        logic [511:0] s;
        for (int k = 0; k < 16; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    // ---------------- DUTs and monitors ----------------
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int R = (g == 0) ? 20 : ((g == 1) ? 2 : 8);

        chacha_inv_permute #(.ROUNDS(R)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
`ifdef CHACHA_INV_PERF_EN
            .blocks_done (blocks_done[g]),
`endif
            .busy      (busy[g])
        );

        bit prev_ov = 1'b0;

        always @(negedge clk) begin
            if (rst) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid[g] && !prev_ov) begin
                    if (acc_q[g].size() == 0) fail("unexpected_out_valid", "out_valid with no accepted state");
                    else check("latency", 512'(cyc - acc_q[g][0]), 512'(R));
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        fail("unexpected_handshake", "handshake with no accepted state");
                    end else begin
                        check("state_out", state_out[g], exp_q[g].pop_front());
                        if (acc_q[g].size() != 0) void'(acc_q[g].pop_front());
                    end
                end
                prev_ov = out_valid[g];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drives at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send(input int g, input logic [511:0] stim, input logic [511:0] req, input bit rnd);
        int budget = 2000;
        @(posedge clk); #1;
        in_valid[g] = 1'b1;
        state_in[g] = stim;
        forever begin
            @(negedge clk);
            if (in_ready[g]) break;
            budget--;
            if (budget == 0) begin
                fail("accept_timeout", "in_ready never high");
                @(posedge clk); #1;
                in_valid[g] = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd) out_ready[g] = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        exp_q[g].push_back(req);
        acc_q[g].push_back(cyc);
        in_valid[g] = 1'b0;
        state_in[g] = rand_state();
        if (rnd) out_ready[g] = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_drain(input int g);
        int budget = 3000;
        while (exp_q[g].size() != 0) begin
            @(negedge clk);
            budget--;
            if (budget == 0) begin
                fail("drain_timeout", "no output handshake");
                exp_q[g].delete();
                acc_q[g].delete();
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_run(input int g, input int n);
        logic [511:0] orig;
        for (int i = 0; i < n; i++) begin
            orig = rand_state();
            send(g, fwd(orig, rounds_of(g)), orig, 1'b1);
        end
        out_ready[g] = 1'b1;
        wait_drain(g);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0]  kin  [16] = '{32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
                                    32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
                                    32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
                                    32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
        logic [31:0]  kout [16] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                                    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                                    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                                    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        logic [511:0] kat_in, kat_out, orig, held;
        int           budget;

        for (int g = 0; g < NI; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
            state_in[g]  = '0;
        end
        for (int i = 0; i < 16; i++) begin
            kat_in[32*i +: 32]  = kin[i];
            kat_out[32*i +: 32] = kout[i];
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) begin
            check("rst_in_ready",  512'(in_ready[g]),  512'(1));
            check("rst_out_valid", 512'(out_valid[g]), 512'(0));
            check("rst_busy",      512'(busy[g]),      512'(0));
            check("rst_state_out", state_out[g],       512'(0));
        end
        rst = 1'b0;

        // Known answer, ROUNDS=20
        out_ready[0] = 1'b1;
        send(0, kat_in, kat_out, 1'b0);
        @(negedge clk);
        check("busy_compute", 512'(busy[0]), 512'(1));
        wait_drain(0);

        // Zero fixed point, ROUNDS=2
        out_ready[1] = 1'b1;
        send(1, '0, '0, 1'b0);
        wait_drain(1);

        // Random round trip over all three round counts
        fork
            rand_run(0, 334);
            rand_run(1, 333);
            rand_run(2, 333);
        join

        // Backpressure and input lockout
        out_ready[0] = 1'b0;
        orig = rand_state();
        send(0, fwd(orig, 20), orig, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        state_in[0] = rand_state();
        repeat (2) begin
            @(negedge clk);
            check("lockout_in_ready", 512'(in_ready[0]), 512'(0));
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        budget = 100;
        do begin
            @(negedge clk);
            budget--;
        end while (!out_valid[0] && budget > 0);
        if (!out_valid[0]) fail("bp_out_valid", "out_valid never rose");
        held = state_out[0];
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_out_valid_hold", 512'(out_valid[0]), 512'(1));
            check("bp_state_hold",     state_out[0],       held);
            check("bp_in_ready_low",   512'(in_ready[0]),  512'(0));
        end
        @(posedge clk); #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        wait_drain(0);
        @(negedge clk);
        check("in_ready_after_hs", 512'(in_ready[0]), 512'(1));
        repeat (25) begin
            @(negedge clk);
            check("no_extra_output", 512'(out_valid[0]), 512'(0));
        end

        // Reset mid-operation
        orig = rand_state();
        send(0, fwd(orig, 20), orig, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int g = 0; g < NI; g++) begin
            exp_q[g].delete();
            acc_q[g].delete();
        end
        #1;
        check("midrst_in_ready",  512'(in_ready[0]),  512'(1));
        check("midrst_out_valid", 512'(out_valid[0]), 512'(0));
        check("midrst_busy",      512'(busy[0]),      512'(0));
        check("midrst_state_out", state_out[0],       512'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check("midrst_no_stale", 512'(out_valid[0]), 512'(0));
        end
        orig = rand_state();
        send(0, fwd(orig, 20), orig, 1'b0);
        wait_drain(0);

`ifdef CHACHA_INV_PERF_EN
        // Handshake counter
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            orig = rand_state();
            send(0, fwd(orig, 20), orig, 1'b0);
        end
        wait_drain(0);
        check("blocks_done_3", 512'(blocks_done[0]), 512'(3));
        force g_inst[0].u_dut.blocks_done_q = 32'hFFFFFFFF;
        @(posedge clk); #1;
        release g_inst[0].u_dut.blocks_done_q;
        orig = rand_state();
        send(0, fwd(orig, 20), orig, 1'b0);
        wait_drain(0);
        check("blocks_done_wrap", 512'(blocks_done[0]), 512'(0));
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chacha_inv_permute.md
# chacha_inv_permute

Iterative inverse of the ChaCha block permutation without the feed-forward addition. It accepts a 16-word state that has been through ROUNDS forward rounds and returns the original pre-round state. The block runs one inverse half-double-round per clock, using four inverse quarter-rounds in parallel. It sits beside the forward ChaCha core and serves state rewind, known-answer self-test and verification cross-checks, behind a valid/ready handshake on both sides.

## Interface
- ROUNDS, 20, forward rounds to undo; must be even and at least 2, checked at elaboration.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept a state; high only in IDLE.
- state_in  input  512  forward-permuted state; word i at [32i+31:32i].
- out_valid  output  1  state_out holds the recovered state.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  512  recovered state, same packing; driven directly from the working register.
- busy  output  1  high in DIAG, COL and DONE.

## Operation
- Inverse quarter-round on (a,b,c,d), all 32-bit mod 2^32:
  - b=ROTR7(b)^c; c=c-d; d=ROTR8(d)^a; a=a-b
  - b=ROTR12(b)^c; c=c-d; d=ROTR16(d)^a; a=a-b
- Diagonal set: (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
- Column set: (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
- Each inverse double-round applies the diagonal set first, then the column set.
- FSM:
  - IDLE: in_ready=1. On in_valid, load state_in into the working register, load dr_cnt=ROUNDS/2, go to DIAG.
  - DIAG: apply the four diagonal inverse QRs to the register, go to COL.
  - COL: apply the four column inverse QRs and decrement dr_cnt. Go to DONE if dr_cnt was 1, else DIAG.
  - DONE: out_valid=1 and the register is frozen. On out_ready, go to IDLE.
- No new input is accepted until the output handshake completes. in_valid outside IDLE is ignored and the block holds no queue.
- The dr_cnt width is clog2(ROUNDS/2+1).

## Timing
- Reset values: state IDLE, working register 0, state_out 0, in_ready 1, out_valid 0, busy 0, dr_cnt 0.
- Latency: the input handshake is at edge E and out_valid rises after edge E+ROUNDS. For ROUNDS=20 that is 20 cycles.
- Throughput: one state per ROUNDS+2 cycles when out_ready is held high. This covers 1 accept cycle, ROUNDS compute cycles and 1 DONE cycle.
- out_valid and state_out stay stable while out_ready=0, for any number of cycles.
- When out_ready is high on the DONE cycle, in_ready goes high on the next cycle. There is no same-cycle pass-through.
- Reset asserted mid-computation forces IDLE immediately, discards the partial state and clears outputs. No out_valid is produced for the aborted state.
- in_valid and out_ready are never combinationally looped to in_ready or out_valid. Both handshake outputs are decoded from the state register only.

## Configuration
- CHACHA_INV_PERF_EN:
  - Defined: adds output port blocks_done (32-bit), a count of completed output handshakes. It resets to 0, increments on each cycle with out_valid&&out_ready, and wraps from 0xFFFFFFFF to 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Known answer (ROUNDS=20):
  - Stimulus: state_in words 0..15 = 837778ab e238d763 a67ae21e 5950bb2f c4f2d0c7 fc62bb2f 8fa018fc 3f5ec7b7 335271c2 f29489f3 eabda8fc 82e46ebd d19c12b4 b04e16de 9e83d0cb 4e3c50a2.
  - Required response: state_out = 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000, with out_valid exactly 20 cycles after the accept edge.
- Zero fixed point (ROUNDS=2): all-zero state_in -> all-zero state_out, out_valid 2 cycles after the accept edge.
- Random round trip: 1000 random states are passed through a forward golden model for ROUNDS in {2,8,20}, then fed to the block -> every state_out equals the original state.
- Backpressure and input lockout:
  - Hold out_ready=0 for 50 cycles -> out_valid and state_out stay constant and in_ready=0 throughout.
  - A second in_valid pulse during compute -> ignored. The next accept happens only after the output handshake.
- Reset mid-operation: assert rst 5 cycles after an accept -> in_ready=1 and out_valid=0 at once, with no stale out_valid. A fresh input then completes correctly.
- With CHACHA_INV_PERF_EN defined:
  - 3 back-to-back blocks -> blocks_done=3.
  - Force the counter to 0xFFFFFFFF, complete one more block -> blocks_done=0.
